// File: rtl/and_sweep_ctrl_pkg.sv
// rtl/and_sweep_ctrl_pkg.sv - shared state encoding and sizing helpers for the AND self-test sweep
// Purpose: state type and width helpers used by the sweep sequencer and its bench.
// Ports: none (package).
package and_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of input vectors for a WIDTH-bit two-operand unit.
    function automatic int nvec(input int width);
        return 1 << (2 * width);
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_sweep_ctrl_sweep_counter.sv
// rtl/and_sweep_ctrl_sweep_counter.sv - vector index counter with clear, increment and terminal flag
// Purpose: holds the {b,a} vector index of the sweep.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : load zero (wins over inc)
//   inc      : advance index by one
//   idx      : current index
//   tc       : index is all ones (last vector)
module and_sweep_ctrl_sweep_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign tc = &idx;

endmodule

// File: rtl/and_sweep_ctrl.sv
// rtl/and_sweep_ctrl.sv - exhaustive self-test sequencer for a WIDTH-bit bitwise AND unit
// Purpose: on start, walks every {b,a} combination, holds each SETTLE cycles,
//          compares v against a&b and reports pass, mismatch count and first failure.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin sweep (honoured only in IDLE or DONE)
//   a_out, b_out      : operands driven to the unit under test
//   v_in              : result returned by the unit under test
//   busy              : sweep in progress (APPLY or CHECK)
//   done              : sweep finished, held until next start or rst
//   pass              : valid with done, 1 when no mismatches were seen
//   err_count         : number of mismatching vectors
//   fail_valid        : a first failing vector has been captured
//   fail_a, fail_b    : operands of the first failing vector
module and_sweep_ctrl
    import and_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   v_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int SW = cnt_bits(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx;
    logic            idx_tc;
    logic            idx_clr;
    logic            idx_inc;
    logic            sweep_start;
    logic [SW-1:0]   settle_cnt;
    logic            mismatch;
    logic [IW:0]     err_nx;

    and_sweep_ctrl_sweep_counter #(
        .W (IW)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (idx_clr),
        .inc (idx_inc),
        .idx (idx),
        .tc  (idx_tc)
    );

    // Operands come straight from the index, so they hold through CHECK
    // and DONE without extra registers; a is the low half (fastest).
    assign a_out = idx[WIDTH-1:0];
    assign b_out = idx[IW-1:WIDTH];

    assign busy = (state == S_APPLY) || (state == S_CHECK);
    assign done = (state == S_DONE);

    assign mismatch = (state == S_CHECK) && (v_in != (a_out & b_out));
    assign err_nx   = err_count + {{IW{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        sweep_start = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx    = S_APPLY;
                    idx_clr     = 1'b1;
                    sweep_start = 1'b1;
                end
            end
            S_APPLY: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                // All-ones index is terminal; never wrap back into APPLY.
                if (idx_tc) begin
                    state_nx = S_DONE;
                end else begin
                    idx_inc  = 1'b1;
                    state_nx = S_APPLY;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Counts APPLY cycles of the current vector; zero whenever not applying
    // so each new vector starts a fresh hold.
    always_ff @(posedge clk) begin
        if (rst || (state != S_APPLY)) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            pass       <= 1'b0;
        end else if (sweep_start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            pass       <= 1'b0;
        end else if (state == S_CHECK) begin
            err_count <= err_nx;
            if (mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_a     <= a_out;
                fail_b     <= b_out;
            end
            // Uses err_nx so a mismatch on the final vector still counts.
            if (idx_tc) begin
                pass <= (err_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_and_sweep_ctrl.sv
// tb/tb_and_sweep_ctrl.sv - self-checking bench for and_sweep_ctrl
module tb_and_sweep_ctrl;
    import and_sweep_ctrl_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       start3;
    logic [1:0] a_out, b_out, v_in;
    logic [1:0] a3, b3, v3;
    logic       busy, done, pass, fail_valid;
    logic       busy3, done3, pass3, fv3;
    logic [4:0] err_count, err3;
    logic [1:0] fail_a, fail_b, fa3, fb3;
    int         mode;

    // Behavioural unit under test: 0 good AND, 1 behaves as OR, 2 bit0 stuck at 1.
    always_comb begin
        case (mode)
            1:       v_in = a_out | b_out;
            2:       v_in = (a_out & b_out) | 2'b01;
            default: v_in = a_out & b_out;
        endcase
    end
    assign v3 = a3 & b3;

    and_sweep_ctrl #(.WIDTH(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out), .v_in(v_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
    );

    and_sweep_ctrl #(.WIDTH(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_out(a3), .b_out(b3), .v_in(v3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    typedef struct {
        int mode;
        int err;
        int fv;
        int fa;
        int fb;
        int pass;
    } vec_t;

    vec_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE/DONE, then follow the sweep to done.
    // poke: cycle at which a stray start pulse is given (0 = none).
    task automatic sweep(input int mode_i, input int poke,
                         output int done_cyc, output int busy_cyc, output int seq_bad);
        int c;
        int v;
        logic [3:0] iv;
        mode     = mode_i;
        start    = 1'b1;
        step();
        start    = 1'b0;
        c        = 1;
        busy_cyc = 0;
        seq_bad  = 0;
        done_cyc = -1;
        while (c < 200) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy) begin
                busy_cyc++;
                v  = (c - 1) / 2;
                iv = v[3:0];
                if ({b_out, a_out} != iv) seq_bad++;
            end
            start = (c == poke);
            step();
            c++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_err"},   int'(err_count),  e.err);
        chk({tag, "_fv"},    int'(fail_valid), e.fv);
        chk({tag, "_fa"},    int'(fail_a),     e.fa);
        chk({tag, "_fb"},    int'(fail_b),     e.fb);
        chk({tag, "_pass"},  int'(pass),       e.pass);
    endtask

    vec_t tbl[3];
    int   dc, bc, sbad, c;
    int   v;
    logic [3:0] iv;

    initial begin
        tbl[0] = '{mode: 0, err: 0,  fv: 0, fa: 0, fb: 0, pass: 1};
        tbl[1] = '{mode: 1, err: 12, fv: 1, fa: 1, fb: 0, pass: 0};
        tbl[2] = '{mode: 2, err: 12, fv: 1, fa: 0, fb: 0, pass: 0};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err",  int'(err_count), 0);
        chk("rst_fv",   int'(fail_valid), 0);
        chk("rst_ab",   int'({b_out, a_out}), 0);
        chk("rst_fab",  int'({fail_b, fail_a}), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            sb.push_back(tbl[i]);
            sweep(tbl[i].mode, (i == 0) ? 10 : 0, dc, bc, sbad);
            chk($sformatf("t%0d_done_cyc", i), dc, 1 + nvec(2) * 2);
            chk($sformatf("t%0d_busy_cyc", i), bc, nvec(2) * 2);
            chk($sformatf("t%0d_vec_seq", i), sbad, 0);
            chk($sformatf("t%0d_hold_ab", i), int'({b_out, a_out}), 15);
            check_result($sformatf("t%0d", i));
        end

        // Back-to-back: start held in DONE restarts the sweep.
        mode = 0;
        sb.push_back(tbl[0]);
        start = 1'b1;
        step();
        c = 34;
        chk("b2b_done_low", int'(done), 0);
        chk("b2b_busy",     int'(busy), 1);
        chk("b2b_err_clr",  int'(err_count), 0);
        chk("b2b_fv_clr",   int'(fail_valid), 0);
        start = 1'b0;
        while (!done && c < 200) begin
            step();
            c++;
        end
        chk("b2b_done_cyc", c, 66);
        check_result("b2b");

        // Reset during CHECK of vector 5 with a faulty unit.
        mode  = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        while (c < 12) begin
            step();
            c++;
        end
        chk("mid_busy",  int'(busy), 1);
        chk("mid_ab",    int'({b_out, a_out}), 5);
        chk("mid_err",   int'(err_count), 4);
        rst = 1'b1;
        step();
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_err",  int'(err_count), 0);
        chk("mrst_fv",   int'(fail_valid), 0);
        chk("mrst_ab",   int'({b_out, a_out}), 0);
        chk("mrst_fab",  int'({fail_b, fail_a}), 0);
        rst = 1'b0;
        step();
        chk("mrst_idle", int'(busy), 0);
        sb.push_back(tbl[0]);
        sweep(0, 0, dc, bc, sbad);
        chk("rerun_done_cyc", dc, 33);
        chk("rerun_vec_seq", sbad, 0);
        check_result("rerun");

        // SETTLE=3 instance.
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        c = 1; bc = 0; sbad = 0;
        while (!done3 && c < 200) begin
            if (busy3) begin
                bc++;
                v  = (c - 1) / 4;
                iv = v[3:0];
                if ({b3, a3} != iv) sbad++;
            end
            step();
            c++;
        end
        chk("s3_done_cyc", c, 1 + nvec(2) * 4);
        chk("s3_busy_cyc", bc, 64);
        chk("s3_vec_seq",  sbad, 0);
        chk("s3_pass",     int'(pass3), 1);
        chk("s3_err",      int'(err3), 0);
        chk("s3_fv",       int'(fv3), 0);
        chk("s3_fab",      int'({fb3, fa3}), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
